// File: rtl/cmul_rr_scheduler_if.sv
// Bundle between the requesters, the shared complex multiplier and the result consumer
// of cmul_rr_scheduler. The slave modport is the scheduler's view of the bundle.
interface cmul_rr_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 18,
    parameter int BWIDTH = 18,
    parameter int IDW    = 2
);
    localparam int PW = AWIDTH + BWIDTH + 1;

    logic                     en;
    logic [NREQ-1:0]          req_mask;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*AWIDTH-1:0]   req_ar;
    logic [NREQ*AWIDTH-1:0]   req_ai;
    logic [NREQ*BWIDTH-1:0]   req_br;
    logic [NREQ*BWIDTH-1:0]   req_bi;
    logic [AWIDTH-1:0]        mul_ar;
    logic [AWIDTH-1:0]        mul_ai;
    logic [BWIDTH-1:0]        mul_br;
    logic [BWIDTH-1:0]        mul_bi;
    logic [PW-1:0]            mul_pr;
    logic [PW-1:0]            mul_pi;
    logic                     res_valid;
    logic [IDW-1:0]           res_id;
    logic [PW-1:0]            res_pr;
    logic [PW-1:0]            res_pi;
    logic                     idle;

    modport slave (
        input  en, req_mask, req_valid, req_ar, req_ai, req_br, req_bi, mul_pr, mul_pi,
        output req_ready, mul_ar, mul_ai, mul_br, mul_bi, res_valid, res_id, res_pr, res_pi, idle
    );

    modport master (
        output en, req_mask, req_valid, req_ar, req_ai, req_br, req_bi, mul_pr, mul_pi,
        input  req_ready, mul_ar, mul_ai, mul_br, mul_bi, res_valid, res_id, res_pr, res_pi, idle
    );
endinterface

// File: rtl/cmul_rr_scheduler.sv
// Round-robin front end for one shared, fixed-latency pipelined complex multiplier.
// A {valid,id} shift pipe runs alongside the multiplier so every product comes back tagged.
module cmul_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int AWIDTH  = 18,
    parameter int BWIDTH  = 18,
    parameter int MUL_LAT = 6,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmul_rr_scheduler_if.slave   bus
);
    localparam int PW = AWIDTH + BWIDTH + 1;

    logic [IDW-1:0]      ptr_r;
    logic [NREQ-1:0]     elig_s;
    logic                found_s;
    logic                hit_s;
    logic [IDW-1:0]      gidx_s;
    logic [IDW-1:0]      ptr_nxt_s;
    logic                xfer_s;

    logic [AWIDTH-1:0]   mul_ar_r;
    logic [AWIDTH-1:0]   mul_ai_r;
    logic [BWIDTH-1:0]   mul_br_r;
    logic [BWIDTH-1:0]   mul_bi_r;

    // Entry 0 shadows the operand register; entries 1..MUL_LAT track the multiplier stages.
    logic [MUL_LAT:0]    pv_r;
    logic [IDW-1:0]      pid_r [MUL_LAT+1];

    logic                res_valid_r;
    logic [IDW-1:0]      res_id_r;
    logic [PW-1:0]       res_pr_r;
    logic [PW-1:0]       res_pi_r;

    assign elig_s = bus.req_valid & bus.req_mask & {NREQ{bus.en}};

    // First eligible requester searching from ptr upward with wrap-around
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        gidx_s  = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            hit_s   = ~found_s & elig_s[(int'(ptr_r) + k) % NREQ];
            gidx_s  = hit_s ? IDW'((int'(ptr_r) + k) % NREQ) : gidx_s;
            found_s = found_s | hit_s;
        end
    end

    assign xfer_s        = found_s & rst_n;
    assign bus.req_ready = xfer_s ? (NREQ'(1'b1) << gidx_s) : {NREQ{1'b0}};
    assign ptr_nxt_s     = (gidx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gidx_s + IDW'(1'b1);

    // Issue register: pointer advance and operand capture on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r    <= {IDW{1'b0}};
            mul_ar_r <= {AWIDTH{1'b0}};
            mul_ai_r <= {AWIDTH{1'b0}};
            mul_br_r <= {BWIDTH{1'b0}};
            mul_bi_r <= {BWIDTH{1'b0}};
        end else if (xfer_s) begin
            ptr_r    <= ptr_nxt_s;
            mul_ar_r <= bus.req_ar[int'(gidx_s)*AWIDTH +: AWIDTH];
            mul_ai_r <= bus.req_ai[int'(gidx_s)*AWIDTH +: AWIDTH];
            mul_br_r <= bus.req_br[int'(gidx_s)*BWIDTH +: BWIDTH];
            mul_bi_r <= bus.req_bi[int'(gidx_s)*BWIDTH +: BWIDTH];
        end
    end

    // Tag pipe: shifts every cycle so it stays in lockstep with the non-stalling multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= {(MUL_LAT+1){1'b0}};
            for (int j = 0; j <= MUL_LAT; j++) begin
                pid_r[j] <= {IDW{1'b0}};
            end
        end else begin
            pv_r     <= {pv_r[MUL_LAT-1:0], xfer_s};
            pid_r[0] <= gidx_s;
            for (int j = 1; j <= MUL_LAT; j++) begin
                pid_r[j] <= pid_r[j-1];
            end
        end
    end

    // Result register: capture the tagged product; data holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_id_r    <= {IDW{1'b0}};
            res_pr_r    <= {PW{1'b0}};
            res_pi_r    <= {PW{1'b0}};
        end else begin
            res_valid_r <= pv_r[MUL_LAT];
            if (pv_r[MUL_LAT]) begin
                res_id_r <= pid_r[MUL_LAT];
                res_pr_r <= bus.mul_pr;
                res_pi_r <= bus.mul_pi;
            end
        end
    end

    assign bus.mul_ar    = mul_ar_r;
    assign bus.mul_ai    = mul_ai_r;
    assign bus.mul_br    = mul_br_r;
    assign bus.mul_bi    = mul_bi_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_pr    = res_pr_r;
    assign bus.res_pi    = res_pi_r;
    assign bus.idle      = ~|pv_r & ~res_valid_r;
endmodule

// File: tb/tb_cmul_rr_scheduler.sv
// Scoreboard bench for cmul_rr_scheduler with a behavioural pipelined complex multiplier.
module tb_cmul_rr_scheduler;
    localparam int NREQ = 4;
    localparam int AW   = 18;
    localparam int BW   = 18;
    localparam int L    = 6;
    localparam int IDW  = 2;
    localparam int PW   = AW + BW + 1;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmul_rr_scheduler_if #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .IDW(IDW)) bus ();

    cmul_rr_scheduler #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .MUL_LAT(L), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic signed [PW-1:0] cre(input logic signed [AW-1:0] a_r, input logic signed [AW-1:0] a_i,
                                                 input logic signed [BW-1:0] b_r, input logic signed [BW-1:0] b_i);
        logic signed [PW-1:0] x, y, z, w;
        x = a_r; y = a_i; z = b_r; w = b_i;
        return x * z - y * w;
    endfunction

    function automatic logic signed [PW-1:0] cim(input logic signed [AW-1:0] a_r, input logic signed [AW-1:0] a_i,
                                                 input logic signed [BW-1:0] b_r, input logic signed [BW-1:0] b_i);
        logic signed [PW-1:0] x, y, z, w;
        x = a_r; y = a_i; z = b_r; w = b_i;
        return x * w + y * z;
    endfunction

    // Shared multiplier stand-in: L-stage pipe, no reset, no stall
    logic signed [PW-1:0] mp_r [L];
    logic signed [PW-1:0] mi_r [L];
    always @(posedge clk) begin
        mp_r[0] <= cre(bus.mul_ar, bus.mul_ai, bus.mul_br, bus.mul_bi);
        mi_r[0] <= cim(bus.mul_ar, bus.mul_ai, bus.mul_br, bus.mul_bi);
        for (int j = 1; j < L; j++) begin
            mp_r[j] <= mp_r[j-1];
            mi_r[j] <= mi_r[j-1];
        end
    end
    assign bus.mul_pr = mp_r[L-1];
    assign bus.mul_pi = mi_r[L-1];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  pr;
        logic [PW-1:0]  pi;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic              en;
    logic [NREQ-1:0]   mask;
    int                pend [NREQ];
    logic [AW-1:0]     oar [NREQ];
    logic [AW-1:0]     oai [NREQ];
    logic [BW-1:0]     obr [NREQ];
    logic [BW-1:0]     obi [NREQ];
    int                mptr;
    int                idle_cnt;
    logic [NREQ-1:0]   exp_rdy;
    logic [NREQ-1:0]   got_rdy;
    logic              xfer_m;
    int                gidx_m;

    // Result checker: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got res_valid=1 id=%0d, required no result", bus.res_id);
            end else begin
                e = sb.pop_front();
                if (bus.res_id !== e.id || bus.res_pr !== e.pr || bus.res_pi !== e.pi) begin
                    n_fail++;
                    $display("FAIL result: got id=%0d pr=%0d pi=%0d, required id=%0d pr=%0d pi=%0d",
                             bus.res_id, $signed(bus.res_pr), $signed(bus.res_pi),
                             e.id, $signed(e.pr), $signed(e.pi));
                end
            end
        end
    end

    task automatic new_operands(input int i);
        oar[i] = AW'($urandom);
        oai[i] = AW'($urandom);
        obr[i] = BW'($urandom);
        obi[i] = BW'($urandom);
    endtask

    task automatic drive_inputs();
        bus.en       = en;
        bus.req_mask = mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]          = (pend[i] > 0);
            bus.req_ar[i*AW +: AW]    = oar[i];
            bus.req_ai[i*AW +: AW]    = oai[i];
            bus.req_br[i*BW +: BW]    = obr[i];
            bus.req_bi[i*BW +: BW]    = obi[i];
        end
    endtask

    // One clock: drive, predict the grant, push expectations, advance to just after the edge
    task automatic step();
        exp_t e;
        int idx;
        drive_inputs();
        #1;
        got_rdy = bus.req_ready;
        exp_rdy = '0;
        xfer_m  = 1'b0;
        gidx_m  = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (!xfer_m && rst_n && pend[idx] > 0 && mask[idx] && en) begin
                xfer_m = 1'b1;
                gidx_m = idx;
            end
        end
        if (xfer_m) begin
            exp_rdy[gidx_m] = 1'b1;
            e.id = IDW'(gidx_m);
            e.pr = cre(oar[gidx_m], oai[gidx_m], obr[gidx_m], obi[gidx_m]);
            e.pi = cim(oar[gidx_m], oai[gidx_m], obr[gidx_m], obi[gidx_m]);
            sb.push_back(e);
            mptr = (gidx_m + 1) % NREQ;
            pend[gidx_m]--;
            new_operands(gidx_m);
        end
        @(posedge clk);
        #1;
        idle_cnt = xfer_m ? 0 : idle_cnt + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en    = 1'b1;
        mask  = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1;
            new_operands(i);
        end
        drive_inputs();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 0000", bus.req_ready);
        end
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.res_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_res: got valid=%b id=%0d, required 0/0", bus.res_valid, bus.res_id);
        end
        n_checks++;
        if (bus.res_pr !== 37'd0 || bus.res_pi !== 37'd0) begin
            n_fail++; $display("FAIL reset_res_data: got pr=%0d pi=%0d, required 0/0", bus.res_pr, bus.res_pi);
        end
        n_checks++;
        if ({bus.mul_ar, bus.mul_ai, bus.mul_br, bus.mul_bi} !== 72'd0) begin
            n_fail++; $display("FAIL reset_mul: got %h, required 0", {bus.mul_ar, bus.mul_ai, bus.mul_br, bus.mul_bi});
        end
        n_checks++;
        if (bus.idle !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle: got %b, required 1", bus.idle);
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        drive_inputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mptr     = 0;
        idle_cnt = 100;
    endtask

    task automatic test_single();
        oar[0] = 18'sd3; oai[0] = 18'sd4; obr[0] = 18'sd5; obi[0] = 18'sd6;
        pend[0] = 1;
        step();
        n_checks++;
        if (got_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b, required 0001", got_rdy);
        end
        for (int c = 0; c < L; c++) step();
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early: got res_valid=%b after %0d edges, required 0", bus.res_valid, L);
        end
        step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 ||
            $signed(bus.res_pr) != -37'sd9 || $signed(bus.res_pi) != 37'sd38) begin
            n_fail++;
            $display("FAIL single_result: got v=%b id=%0d pr=%0d pi=%0d, required v=1 id=0 pr=-9 pi=38",
                     bus.res_valid, bus.res_id, $signed(bus.res_pr), $signed(bus.res_pi));
        end
        n_checks++;
        if (bus.idle !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_busy: got %b, required 0", bus.idle);
        end
        step();
        n_checks++;
        if (bus.idle !== 1'b1) begin
            n_fail++; $display("FAIL single_idle_done: got %b, required 1", bus.idle);
        end
    endtask

    task automatic test_fairness();
        int run;
        int max_run;
        logic [NREQ-1:0] want;
        run = 0;
        max_run = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 3;
        for (int c = 0; c < 22; c++) begin
            step();
            if (c < 12) begin
                want = 4'b0001 << ((c + 1) % NREQ);
                n_checks++;
                if (got_rdy !== want) begin
                    n_fail++; $display("FAIL fair_grant%0d: got %b, required %b", c, got_rdy, want);
                end
            end
            run = bus.res_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        n_checks++;
        if (max_run != 12) begin
            n_fail++; $display("FAIL fair_back_to_back: got run of %0d results, required 12", max_run);
        end
    endtask

    task automatic test_mask_en();
        mask = 4'b1010;
        for (int i = 0; i < NREQ; i++) pend[i] = 2;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (got_rdy !== exp_rdy || (got_rdy & ~mask) != 4'b0000) begin
                n_fail++; $display("FAIL mask_grant%0d: got %b, required %b", c, got_rdy, exp_rdy);
            end
        end
        pend[1] = 1;
        pend[3] = 1;
        en = 1'b0;
        step();
        n_checks++;
        if (got_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL en_off_ready: got %b, required 0000", got_rdy);
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (bus.idle !== (idle_cnt > L + 1)) begin
                n_fail++; $display("FAIL drain_idle%0d: got %b, required %b", c, bus.idle, (idle_cnt > L + 1));
            end
            step();
        end
        en   = 1'b1;
        mask = 4'hF;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
    endtask

    task automatic test_wrap();
        pend[2] = 1;
        step();
        n_checks++;
        if (got_rdy !== 4'b0100) begin
            n_fail++; $display("FAIL wrap_setup: got %b, required 0100", got_rdy);
        end
        pend[1] = 1;
        step();
        n_checks++;
        if (got_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_sparse: got %b, required 0010", got_rdy);
        end
        pend[0] = 1;
        step();
        n_checks++;
        if (got_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_search: got %b, required 0001", got_rdy);
        end
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        pend[0] = 1; pend[1] = 1; pend[2] = 1;
        for (int c = 0; c < 6; c++) step();
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (bus.idle !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_clear: got idle=%b v=%b, required 1/0", bus.idle, bus.res_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mptr     = 0;
        idle_cnt = 100;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.res_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || bus.idle !== 1'b1) begin
            n_fail++; $display("FAIL midreset_drop: got %0d results idle=%b, required 0 results idle=1", seen, bus.idle);
        end
        pend[0] = 1; pend[3] = 1;
        step();
        n_checks++;
        if (got_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL midreset_ptr: got %b, required 0001", got_rdy);
        end
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_extremes();
        oar[1] = 18'h20000; oai[1] = 18'h20000; obr[1] = 18'h20000; obi[1] = 18'h1FFFF;
        pend[1] = 1;
        step();
        for (int c = 0; c < L + 1; c++) step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 ||
            $signed(bus.res_pr) != 37'sd34359607296 || $signed(bus.res_pi) != 37'sd131072) begin
            n_fail++;
            $display("FAIL extremes: got v=%b id=%0d pr=%0d pi=%0d, required v=1 id=1 pr=34359607296 pi=131072",
                     bus.res_valid, bus.res_id, $signed(bus.res_pr), $signed(bus.res_pi));
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_mask_en();
        test_wrap();
        test_reset_midflight();
        test_extremes();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL missing_results: got %0d outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
